rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one resource slot among requesters and drives a one-hot grant vector from a registered 2-bit grant index. It sits in front of a shared resource: requesters raise `req`, one owner at a time receives a one-hot `gnt`, and ownership ends on release or on a hold-time limit. Fairness is strict round-robin: priority rotates to the requester after the last owner.

---
 rtl/arb_pkg.sv | 39 +++
 rtl/rr_arbiter4_grant_decoder.sv | 19 +
 rtl/rr_arbiter4.sv | 111 +++++++++++
 tb/tb_rr_arbiter4.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the rr_arbiter4 round-robin arbiter.
//   NUM_REQ     : number of requesters (4)
//   IDX_W       : width of a binary requester index (2)
//   state_t     : arbiter FSM state encoding (IDLE, BUSY)
//   rr_next_idx : round-robin priority search starting just after the last owner
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Returns the first set bit of req searching from last+1 upward, wrapping
  // modulo NUM_REQ. The 2-bit addition wraps naturally, so k = NUM_REQ lands
  // back on last itself, giving the last owner the lowest priority. The
  // caller only uses the result when req is nonzero.
  function automatic logic [IDX_W-1:0] rr_next_idx(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_grant_decoder.sv
// grant_decoder: combinational 2-to-4 one-hot decoder with enable.
//   idx    : binary index of the selected requester
//   en     : when low the output is all zeros
//   onehot : one-hot decode of idx (at most one bit set)
module grant_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  // Each bit compares against its own constant, so two bits can never be
  // set at once.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
    assign onehot[gi] = en && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a hold-time limit.
// One owner at a time holds a registered grant; ownership ends when the
// owner drops its request or after MAX_HOLD cycles, whichever comes first.
// Every grant is followed by one idle cycle before the next grant.
//   MAX_HOLD  : max consecutive grant cycles per owner (2..255)
//   CNT_W     : hold counter width, MAX_HOLD <= 2**CNT_W - 1
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       : level request vector, bit i = requester i
//   gnt       : one-hot grant, zero when there is no owner
//   gnt_idx   : index of the current or most recent owner
//   gnt_valid : high while gnt is nonzero
//   timeout   : one-cycle pulse on forced release
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] req_clean;

  // Only a definite 1 counts as a request; X or Z in simulation reads as 0.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_clean[gi] = (req[gi] === 1'b1);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_clean) begin
          idx_d   = rr_next_idx(req_clean, last_q);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Release is checked first so a drop on the final hold cycle
        // ends ownership quietly, without a timeout pulse.
        if (!req_clean[idx_q]) begin
          valid_d = 1'b0;
          last_d  = idx_q;
          state_d = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          valid_d   = 1'b0;
          last_d    = idx_q;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '1;  // points at requester 3, so requester 0 wins first
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  grant_decoder u_grant_decoder (
    .idx    (idx_q),
    .en     (valid_q),
    .onehot (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 (MAX_HOLD = 4). Each cycle the bench
// drives req/rst, predicts the post-edge outputs with a behavioural model,
// queues the prediction, and compares it with the DUT after the edge.
// Directed checks cover grant order, hold/timeout patterns and reset.
module tb_rr_arbiter4;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  bit m_busy;
  int m_idx;
  int m_cnt;
  int m_last;
  bit m_to;

  logic [31:0] vhist;
  logic [31:0] thist;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rs);
    bit found;
    int c;
    if (rs) begin
      m_busy = 0; m_idx = 0; m_cnt = 0; m_last = 3; m_to = 0;
    end else if (!m_busy) begin
      m_to  = 0;
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && r[c] === 1'b1) begin
          found  = 1;
          m_idx  = c;
          m_cnt  = 0;
          m_busy = 1;
        end
      end
    end else if (r[m_idx] !== 1'b1) begin
      m_busy = 0; m_last = m_idx; m_to = 0;
    end else if (m_cnt == MAXH - 1) begin
      m_busy = 0; m_last = m_idx; m_to = 1;
    end else begin
      m_cnt++;
      m_to = 0;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(r, rs);
    e.gnt   = m_busy ? 4'(1 << m_idx) : 4'b0000;
    e.idx   = 2'(m_idx);
    e.valid = m_busy;
    e.to    = m_to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("gnt",       32'(gnt),       32'(e.gnt));
    check_val("gnt_idx",   32'(gnt_idx),   32'(e.idx));
    check_val("gnt_valid", 32'(gnt_valid), 32'(e.valid));
    check_val("timeout",   32'(timeout),   32'(e.to));
    check_val("onehot0",   32'($onehot0(gnt)), 32'd1);
    vhist = {vhist[30:0], gnt_valid};
    thist = {thist[30:0], timeout};
    $display("[TB] t=%0t rst=%b req=%b gnt=%b idx=%0d valid=%b timeout=%b",
             $time, rs, r, gnt, gnt_idx, gnt_valid, timeout);
  endtask

  initial begin : main
    logic [3:0] r;
    int         age [4];
    bit         wt  [4];
    int         ord [5];
    int         order_n;
    logic       prev_valid;

    rst = 1'b1;
    req = 4'b0000;
    ord = '{0, 1, 2, 3, 0};

    // reset values
    step(4'b0000, 1'b1);
    check_val("rst_gnt",   32'(gnt),     32'h0);
    check_val("rst_idx",   32'(gnt_idx), 32'h0);
    check_val("rst_valid", 32'(gnt_valid), 32'h0);

    // single requester, grant then release
    step(4'b0001, 1'b0);
    check_val("basic_gnt", 32'(gnt), 32'h1);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check_val("basic_rel", 32'(gnt), 32'h0);

    // idle for 20 cycles after reset
    step(4'b0000, 1'b1);
    vhist = '0;
    for (int i = 0; i < 20; i++) step(4'b0000, 1'b0);
    check_val("idle_valid_hist", vhist[19:0], 32'h0);

    // all requesting, each owner drops 2 cycles after grant, reasserts later
    step(4'b0000, 1'b1);
    r = 4'b1111;
    for (int i = 0; i < 4; i++) begin age[i] = 0; wt[i] = 0; end
    order_n    = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_busy && m_idx == i) begin
          age[i]++;
          if (age[i] >= 3) r[i] = 1'b0;
        end else begin
          age[i] = 0;
          if (!r[i]) begin
            if (wt[i]) begin r[i] = 1'b1; wt[i] = 0; end
            else wt[i] = 1;
          end
        end
      end
      step(r, 1'b0);
      if (gnt_valid && !prev_valid && order_n < 5) begin
        check_val($sformatf("order%0d", order_n), 32'(gnt_idx), 32'(ord[order_n]));
        order_n++;
      end
      prev_valid = gnt_valid;
    end
    check_val("order_count", 32'(order_n), 32'd5);

    // single requester held: 4 grant cycles, timeout, regrant
    step(4'b0000, 1'b1);
    vhist = '0;
    thist = '0;
    for (int i = 0; i < 12; i++) step(4'b0100, 1'b0);
    check_val("hold_pattern",    vhist[11:0], 32'b1111_0111_1011);
    check_val("timeout_pattern", thist[11:0], 32'b0000_1000_0100);

    // timed-out owner 1 loses priority to 3; release on last cycle is quiet
    step(4'b0000, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      step(4'b1010, 1'b0);
      if (i == 1)  check_val("to_first_idx", 32'(gnt_idx), 32'd1);
      if (i == 5)  check_val("to_pulse",     32'(timeout), 32'd1);
      if (i == 6)  check_val("to_next_idx",  32'(gnt_idx), 32'd3);
      if (i == 11) check_val("to_back_idx",  32'(gnt_idx), 32'd1);
    end
    step(4'b1000, 1'b0);
    check_val("rel_no_timeout", 32'(timeout),   32'd0);
    check_val("rel_valid",      32'(gnt_valid), 32'd0);

    // reset in the middle of a grant
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    check_val("pre_rst_gnt", 32'(gnt), 32'h8);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    check_val("mid_rst_gnt", 32'(gnt),     32'h0);
    check_val("mid_rst_to",  32'(timeout), 32'h0);
    step(4'b1001, 1'b0);
    check_val("post_rst_gnt", 32'(gnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
